ldm_stm_seq: RTL and testbench
==============================

# ldm_stm_seq

Multi-register transfer sequencer for the multicycle ARM core. It issues LDM/STM block transfers one register per cycle: data-memory addresses and write enables on one side, register-file read and write addresses and enables on the other. The controller hands it a decoded instruction plus the sampled base register. It holds the controller off with `busy` until the final cycle. Base writeback goes out on the register file's second write port (`WE4`/`WA4`/`WD4`) during the last transfer cycle, so writeback costs no extra cycle.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- reglist  in  16  register list, bit i = Ri
- rn  in  4  base register index
- base  in  32  value of Rn, sampled with `start`
- load  in  1  1 = LDM, 0 = STM
- pre  in  1  P bit: increment/decrement before
- up  in  1  U bit: 1 = ascending from base
- wb  in  1  W bit: write back final base
- mem_rdata  in  32  data-memory read data (combinational read)
- busy  out  1  sequencer active
- done  out  1  one-cycle completion pulse
- mem_addr  out  32  data-memory address
- mem_we  out  1  data-memory write enable (STM)
- rf_ra  out  4  register read address for store data (drives ra2)
- rf_we3, rf_wa3, rf_wd3  out  1/4/32  load destination write; `rf_wd3` = `mem_rdata`
- pc_we  out  1  load into R15, replaces `rf_we3` when the index is 15
- rf_we4, rf_wa4, rf_wd4  out  1/4/32  base writeback

## Operation
- States: IDLE, XFER, DONE.
- **IDLE, start=1:**
  - Latch `reglist` into `mask`. Latch `rn`, `load`, `wb`.
  - n = popcount(reglist), 0..16.
  - Start address (32-bit, wraps modulo 2^32):
    - IA: base.
    - IB: base+4.
    - DA: base−4n+4.
    - DB: base−4n.
  - Final base: up ? base+4n : base−4n.
- **Next state from IDLE:** n=0 → DONE (no transfers, no writeback); otherwise → XFER.
- **Each XFER cycle:**
  - idx = lowest set bit of `mask`; `mem_addr` = addr_q; `rf_ra` = idx.
  - STM: `mem_we`=1.
  - LDM: `rf_we3`=1 with `rf_wa3`=idx, or `pc_we`=1 instead if idx=15.
  - Then clear bit idx and add 4 to addr_q.
- **Order:** registers always go in ascending index order to ascending addresses, whatever `up` is.
- **Last XFER cycle** (exactly one bit left in `mask`):
  - If `wb`, assert `rf_we4` with `rf_wa4`=rn and `rf_wd4`=final base.
  - Next state → DONE.
- **LDM with wb and Rn in reglist:** writeback is suppressed; the loaded value wins.
- **DONE:** `done`=1 for one cycle, then → IDLE.
- All enables (`mem_we`, `rf_we3`, `pc_we`, `rf_we4`) are 0 outside XFER.

## Timing
- Reset values, all outputs: `busy`=0, `done`=0, `mem_addr`=0, `mem_we`=0, `rf_ra`=0, `rf_we3`=0, `rf_wa3`=0, `pc_we`=0, `rf_we4`=0, `rf_wa4`=0, `rf_wd4`=0.
- State resets to IDLE. `rf_wd3` follows `mem_rdata` combinationally.
- **Sequence:** `start` accepted at edge T. XFER occupies cycles T+1..T+n, DONE is cycle T+n+1, IDLE again at T+n+2. Total latency n+2 cycles.
- `busy`=1 from T+1 through T+n+1 inclusive.
- `start` while `busy` is ignored. Inputs other than `mem_rdata` are don't-care after T.
- All outputs are registered except `rf_wd3`.
- Asserting `reset_n`=0 mid-transfer aborts immediately: no further memory or register writes, no `done`.
- Address overflow past 0xFFFFFFFC wraps silently.

## Structure
- Shared package `arm_pkg`:
  - state encoding (IDLE=2'd0, XFER=2'd1, DONE=2'd2);
  - constant `PC_IDX`=4'd15;
  - word stride 32'd4.
- Sub-module `lowest_set16`: combinational priority encoder, 16-bit mask → 4-bit index plus `valid`.
- Popcount is an inline function in the top level.

## Test plan
- **STMIA, no writeback:** reglist=0x0016, base=0x100, wb=0.
  - 3 cycles: addr 0x100/0x104/0x108 with `mem_we`=1 and `rf_ra`=1/2/4.
  - `done` at T+4; no `rf_we4`.
- **LDMDB with writeback:** rn=13, base=0x200, reglist=0x4010, wb=1.
  - addr 0x1F8 → R4, then 0x1FC → R14.
  - `rf_we4`=1, `rf_wa4`=13, `rf_wd4`=0x1F8 only in the 2nd XFER cycle.
- **LDMIB including PC:** reglist=0x8001, base=0x40.
  - R0 ← mem[0x44] via `rf_we3`.
  - PC ← mem[0x48] via `pc_we`=1 with `rf_we3`=0.
- **Empty list:** reglist=0, wb=1.
  - No enables asserted; `busy`=1 for exactly 1 cycle with `done`=1; `rf_we4` stays 0.
- **Rn in list:** LDMIA with rn=2, reglist=0x0004, wb=1 → `rf_we3` writes R2 and `rf_we4` stays 0.
- **Robustness:**
  - `start` pulsed mid-XFER is ignored.
  - reset_n=0 during the 2nd of 4 transfers → all outputs 0 at once, no `done`.
  - Next `start` after release runs normally.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam logic [3:0]  PC_IDX      = 4'd15;
    localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Controller/memory/register-file bundle seen by the LDM/STM sequencer.
interface ldm_stm_seq_if;

    logic        start;
    logic [15:0] reglist;
    logic [3:0]  rn;
    logic [31:0] base;
    logic        load;
    logic        pre;
    logic        up;
    logic        wb;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  rf_ra;
    logic        rf_we3;
    logic [3:0]  rf_wa3;
    logic [31:0] rf_wd3;
    logic        pc_we;
    logic        rf_we4;
    logic [3:0]  rf_wa4;
    logic [31:0] rf_wd4;

    modport master (
        output start, reglist, rn, base, load, pre, up, wb, mem_rdata,
        input  busy, done, mem_addr, mem_we, rf_ra, rf_we3, rf_wa3, rf_wd3,
               pc_we, rf_we4, rf_wa4, rf_wd4
    );

    modport slave (
        input  start, reglist, rn, base, load, pre, up, wb, mem_rdata,
        output busy, done, mem_addr, mem_we, rf_ra, rf_we3, rf_wa3, rf_wd3,
               pc_we, rf_we4, rf_wa4, rf_wd4
    );

endinterface

// File: rtl/lowest_set16.sv
// Priority encoder: index of the lowest set bit of a 16-bit register mask.
module lowest_set16 (
    input  logic [15:0] mask_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    // Scan from the top so the lowest set bit is the last one to win
    always_comb begin
        idx_o   = 4'd0;
        valid_o = |mask_i;
        for (int i = 15; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = 4'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: one register per cycle, base writeback folded into the last transfer.
module ldm_stm_seq
    import arm_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    ldm_stm_seq_if.slave bus
);

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    seq_state_e  state_q, state_d;
    logic [15:0] mask_q, mask_d;
    logic [31:0] addr_q, addr_d, fin_q, fin_d;
    logic [3:0]  rn_q, rn_d;
    logic        load_q, load_d, wb_q, wb_d, supp_q, supp_d;

    logic        busy_q, busy_d, done_q, done_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, rf_wd4_q, rf_wd4_d;
    logic [3:0]  rf_ra_q, rf_ra_d, rf_wa3_q, rf_wa3_d, rf_wa4_q, rf_wa4_d;
    logic        rf_we3_q, rf_we3_d, pc_we_q, pc_we_d, rf_we4_q, rf_we4_d;

    logic [4:0]  n_s;
    logic [31:0] span_s, start_addr_s, start_fin_s;
    logic [15:0] src_mask_s, onehot_s;
    logic [31:0] src_addr_s, src_fin_s;
    logic [3:0]  src_rn_s, enc_idx_s;
    logic        src_load_s, src_wb_s, src_supp_s, enc_valid_s, idle_s;

    assign n_s         = popcount16(bus.reglist);
    assign span_s      = {25'd0, n_s, 2'b00};
    assign start_fin_s = bus.up ? (bus.base + span_s) : (bus.base - span_s);

    // First transfer address for IA/IB/DA/DB
    always_comb begin
        case ({bus.pre, bus.up})
            2'b01:   start_addr_s = bus.base;
            2'b11:   start_addr_s = bus.base + WORD_STRIDE;
            2'b00:   start_addr_s = bus.base - span_s + WORD_STRIDE;
            2'b10:   start_addr_s = bus.base - span_s;
            default: start_addr_s = bus.base;
        endcase
    end

    // The upcoming transfer comes straight from the inputs in IDLE, from the latched context otherwise
    assign idle_s     = (state_q == IDLE);
    assign src_mask_s = idle_s ? bus.reglist : mask_q;
    assign src_addr_s = idle_s ? start_addr_s : addr_q;
    assign src_fin_s  = idle_s ? start_fin_s : fin_q;
    assign src_rn_s   = idle_s ? bus.rn : rn_q;
    assign src_load_s = idle_s ? bus.load : load_q;
    assign src_wb_s   = idle_s ? bus.wb : wb_q;
    assign src_supp_s = idle_s ? (bus.load & bus.reglist[bus.rn]) : supp_q;
    assign onehot_s   = 16'd1 << enc_idx_s;

    lowest_set16 u_lowest (
        .mask_i  (src_mask_s),
        .idx_o   (enc_idx_s),
        .valid_o (enc_valid_s)
    );

    // Next state, context latch and next-cycle registered outputs
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        fin_d      = fin_q;
        rn_d       = rn_q;
        load_d     = load_q;
        wb_d       = wb_q;
        supp_d     = supp_q;
        mem_addr_d = 32'd0;
        mem_we_d   = 1'b0;
        rf_ra_d    = 4'd0;
        rf_we3_d   = 1'b0;
        rf_wa3_d   = 4'd0;
        pc_we_d    = 1'b0;
        rf_we4_d   = 1'b0;
        rf_wa4_d   = 4'd0;
        rf_wd4_d   = 32'd0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    fin_d   = src_fin_s;
                    rn_d    = src_rn_s;
                    load_d  = src_load_s;
                    wb_d    = src_wb_s;
                    supp_d  = src_supp_s;
                    state_d = (n_s == 5'd0) ? DONE : XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER:    state_d = (mask_q == 16'd0) ? DONE : XFER;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // mask_q/addr_q always describe what is still to be issued after the presented cycle
        if ((state_d == XFER) && enc_valid_s) begin
            mask_d     = src_mask_s & ~onehot_s;
            addr_d     = src_addr_s + WORD_STRIDE;
            mem_addr_d = src_addr_s;
            rf_ra_d    = enc_idx_s;
            mem_we_d   = ~src_load_s;
            if (src_load_s && (enc_idx_s == PC_IDX)) begin
                pc_we_d = 1'b1;
            end else if (src_load_s) begin
                rf_we3_d = 1'b1;
                rf_wa3_d = enc_idx_s;
            end else begin
                rf_we3_d = 1'b0;
            end
            if (src_wb_s && !src_supp_s && ((src_mask_s & ~onehot_s) == 16'd0)) begin
                rf_we4_d = 1'b1;
                rf_wa4_d = src_rn_s;
                rf_wd4_d = src_fin_s;
            end else begin
                rf_we4_d = 1'b0;
            end
        end else begin
            mem_we_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, context and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mask_q     <= 16'd0;
            addr_q     <= 32'd0;
            fin_q      <= 32'd0;
            rn_q       <= 4'd0;
            load_q     <= 1'b0;
            wb_q       <= 1'b0;
            supp_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_we_q   <= 1'b0;
            rf_ra_q    <= 4'd0;
            rf_we3_q   <= 1'b0;
            rf_wa3_q   <= 4'd0;
            pc_we_q    <= 1'b0;
            rf_we4_q   <= 1'b0;
            rf_wa4_q   <= 4'd0;
            rf_wd4_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            fin_q      <= fin_d;
            rn_q       <= rn_d;
            load_q     <= load_d;
            wb_q       <= wb_d;
            supp_q     <= supp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            rf_ra_q    <= rf_ra_d;
            rf_we3_q   <= rf_we3_d;
            rf_wa3_q   <= rf_wa3_d;
            pc_we_q    <= pc_we_d;
            rf_we4_q   <= rf_we4_d;
            rf_wa4_q   <= rf_wa4_d;
            rf_wd4_q   <= rf_wd4_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.rf_ra    = rf_ra_q;
    assign bus.rf_we3   = rf_we3_q;
    assign bus.rf_wa3   = rf_wa3_q;
    assign bus.rf_wd3   = bus.mem_rdata;
    assign bus.pc_we    = pc_we_q;
    assign bus.rf_we4   = rf_we4_q;
    assign bus.rf_wa4   = rf_wa4_q;
    assign bus.rf_wd4   = rf_wd4_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: hand-computed per-cycle expectations for each transfer mode.
module tb_ldm_stm_seq;

    localparam logic [31:0] RD_KEY = 32'hDEAD_0000;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    ldm_stm_seq_if bus ();

    ldm_stm_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Memory model: read data is a keyed function of the address
    assign bus.mem_rdata = bus.mem_addr ^ RD_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] rl, input logic [3:0] r, input logic [31:0] b,
                            input logic ld, input logic p, input logic u, input logic w);
        bus.reglist = rl;
        bus.rn      = r;
        bus.base    = b;
        bus.load    = ld;
        bus.pre     = p;
        bus.up      = u;
        bus.wb      = w;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    task automatic chk_xfer(input string tag, input logic [31:0] addr, input logic [3:0] ra,
                            input logic mwe, input logic we3, input logic pcwe,
                            input logic we4, input logic [3:0] wa4, input logic [31:0] wd4);
        check_val({tag, ".busy"},   32'(bus.busy),     32'd1);
        check_val({tag, ".done"},   32'(bus.done),     32'd0);
        check_val({tag, ".addr"},   bus.mem_addr,      addr);
        check_val({tag, ".ra"},     32'(bus.rf_ra),    32'(ra));
        check_val({tag, ".mem_we"}, 32'(bus.mem_we),   32'(mwe));
        check_val({tag, ".we3"},    32'(bus.rf_we3),   32'(we3));
        check_val({tag, ".pc_we"},  32'(bus.pc_we),    32'(pcwe));
        check_val({tag, ".we4"},    32'(bus.rf_we4),   32'(we4));
        if (we3) begin
            check_val({tag, ".wa3"}, 32'(bus.rf_wa3), 32'(ra));
            check_val({tag, ".wd3"}, bus.rf_wd3,      addr ^ RD_KEY);
        end
        if (we4) begin
            check_val({tag, ".wa4"}, 32'(bus.rf_wa4), 32'(wa4));
            check_val({tag, ".wd4"}, bus.rf_wd4,      wd4);
        end
    endtask

    task automatic chk_done(input string tag);
        check_val({tag, ".done"},   32'(bus.done),   32'd1);
        check_val({tag, ".busy"},   32'(bus.busy),   32'd1);
        check_val({tag, ".mem_we"}, 32'(bus.mem_we), 32'd0);
        check_val({tag, ".we3"},    32'(bus.rf_we3), 32'd0);
        check_val({tag, ".pc_we"},  32'(bus.pc_we),  32'd0);
        check_val({tag, ".we4"},    32'(bus.rf_we4), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        check_val({tag, ".busy"},   32'(bus.busy),   32'd0);
        check_val({tag, ".done"},   32'(bus.done),   32'd0);
        check_val({tag, ".mem_we"}, 32'(bus.mem_we), 32'd0);
        check_val({tag, ".we3"},    32'(bus.rf_we3), 32'd0);
        check_val({tag, ".pc_we"},  32'(bus.pc_we),  32'd0);
        check_val({tag, ".we4"},    32'(bus.rf_we4), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_idle(tag);
        check_val({tag, ".addr"}, bus.mem_addr,      32'd0);
        check_val({tag, ".ra"},   32'(bus.rf_ra),    32'd0);
        check_val({tag, ".wa3"},  32'(bus.rf_wa3),   32'd0);
        check_val({tag, ".wa4"},  32'(bus.rf_wa4),   32'd0);
        check_val({tag, ".wd4"},  bus.rf_wd4,        32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.reglist = 16'd0;
        bus.rn    = 4'd0;
        bus.base  = 32'd0;
        bus.load  = 1'b0;
        bus.pre   = 1'b0;
        bus.up    = 1'b0;
        bus.wb    = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        reset_n = 1'b1;
        step();
        chk_idle("post_reset");

        // STMIA, no writeback
        start_op(16'h0016, 4'd0, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_xfer("stmia.c1", 32'h100, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        chk_xfer("stmia.c2", 32'h104, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        chk_xfer("stmia.c3", 32'h108, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        chk_done("stmia.done");
        step();
        chk_idle("stmia.idle");

        // LDMDB with writeback of R13
        start_op(16'h4010, 4'd13, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1);
        chk_xfer("ldmdb.c1", 32'h1F8, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        chk_xfer("ldmdb.c2", 32'h1FC, 4'd14, 1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h1F8);
        step();
        chk_done("ldmdb.done");
        step();
        chk_idle("ldmdb.idle");

        // LDMIB including PC
        start_op(16'h8001, 4'd1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_xfer("ldmib.c1", 32'h44, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        chk_xfer("ldmib.c2", 32'h48, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
        step();
        chk_done("ldmib.done");
        step();
        chk_idle("ldmib.idle");

        // Empty list: straight to DONE, no writeback
        start_op(16'h0000, 4'd3, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_done("empty.done");
        step();
        chk_idle("empty.idle");

        // LDMIA with Rn in the list: load wins over writeback
        start_op(16'h0004, 4'd2, 32'h500, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_xfer("rnin.c1", 32'h500, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        chk_done("rnin.done");
        step();
        chk_idle("rnin.idle");

        // STMIA with writeback, start pulsed mid-transfer
        start_op(16'h00F0, 4'd9, 32'h1000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_xfer("midst.c1", 32'h1000, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        bus.start   = 1'b1;
        bus.reglist = 16'h0003;
        bus.base    = 32'h9000;
        step();
        bus.start   = 1'b0;
        chk_xfer("midst.c2", 32'h1004, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        chk_xfer("midst.c3", 32'h1008, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        chk_xfer("midst.c4", 32'h100C, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 32'h1010);
        step();
        chk_done("midst.done");
        step();
        chk_idle("midst.idle");

        // LDMDA aborted by reset during the second of four transfers
        start_op(16'h00F0, 4'd1, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_xfer("abort.c1", 32'h1FF4, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        chk_xfer("abort.c2", 32'h1FF8, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort.now");
        step();
        chk_all_zero("abort.hold1");
        step();
        chk_all_zero("abort.hold2");
        reset_n = 1'b1;
        step();
        chk_idle("abort.rel");

        // STMIB with wrap past 0xFFFFFFFC, writeback wraps to zero
        start_op(16'h0003, 4'd5, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_xfer("wrap.c1", 32'hFFFF_FFFC, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        chk_xfer("wrap.c2", 32'h0000_0000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 32'h0000_0000);
        step();
        chk_done("wrap.done");
        step();
        chk_idle("wrap.idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
